pipe_seq_ctrl: RTL and testbench
================================

# pipe_seq_ctrl

Pipeline sequencer for the five-stage MIPS core with exceptions and interrupts. It owns every enable and flush line of the F/D/E/M/W pipeline registers, including `int_clr` into the M/W register. It also owns the PC source select. Internally it runs the multi-cycle mult/div busy counter and a small FSM that sequences exception entry and `eret` return. It sits beside the hazard unit and CP0; all pipeline registers and the PC mux take their control from it.

## Interface
- `MULT_CYC`, default 5: busy cycles for mult/multu.
- `DIV_CYC`, default 10: busy cycles for div/divu; both parameters must be ≤ 15.
- `clk` in 1: single clock; everything updates on posedge.
- `reset` in 1: synchronous, active-high.
- `int_req_M` in 1: CP0 takes an exception/interrupt on the instruction in M.
- `eret_M` in 1: `eret` is in M.
- `load_use_D` in 1: hazard unit requests a load-use stall.
- `md_start_E` in 1: a mult/div is in E this cycle.
- `md_div_E` in 1: qualifies `md_start_E`; 1 = div, 0 = mult.
- `md_use_D` in 1: instruction in D is mult/div/mfhi/mflo/mthi/mtlo.
- `en_F` out 1: PC register enable.
- `en_D` out 1: F/D register enable.
- `clr_E` out 1: D/E register loads a bubble.
- `int_clr` out 1: flushes F/D, D/E, E/M and M/W on the next posedge.
- `pc_sel` out 2: 00 = sequential/branch, 01 = handler 0x0000_4180, 10 = EPC.
- `exl_set` out 1: one-cycle pulse telling CP0 to set EXL and latch EPC.
- `md_busy` out 1: the mult/div unit is busy.
- `md_cnt` out 4: remaining busy cycles.

## Operation
- **FSM states:** RUN, EXC_FETCH, ERET_FETCH.
- **Priority in RUN:** reset > `int_req_M` > `eret_M` > stall > normal.
- **RUN with `int_req_M`=1 (same cycle, combinational):**
  - Outputs: `int_clr`=1, `pc_sel`=01, `exl_set`=1, `en_F`=1, `en_D`=1, `clr_E`=0.
  - Next state: EXC_FETCH.
- **RUN with `eret_M`=1 and `int_req_M`=0:**
  - Outputs: `int_clr`=1, `pc_sel`=10, `en_F`=1, `exl_set`=0.
  - Next state: ERET_FETCH.
- **EXC_FETCH and ERET_FETCH:** each lasts exactly one cycle.
  - Outputs: `int_clr`=0, `pc_sel`=00, `en_F`=1, `en_D`=1, `clr_E`=1.
  - `int_req_M`, `eret_M`, `load_use_D` and `md_start_E` are ignored.
  - Next state: RUN.
- **Stall condition** (RUN only): stall = `load_use_D` | (`md_use_D` & (`md_busy` | `md_start_E`)).
  - On stall: `en_F`=0, `en_D`=0, `clr_E`=1.
  - Otherwise: `en_F`=`en_D`=1, `clr_E`=0.
  - `int_clr` overrides stall: during a flush the stall outputs are forced to the flush values.
- **Mult/div counter:**
  - Load: when `md_start_E`=1, `md_busy`=0, state = RUN and `int_clr`=0, `md_cnt` loads `DIV_CYC` if `md_div_E`=1, else `MULT_CYC`.
  - Decrement: while `md_cnt`≠0 it decrements by 1 each cycle and saturates at 0.
  - `md_busy` = (`md_cnt`≠0); it is registered-derived, not combinational from `md_start_E`.
  - `md_start_E` while `md_busy`=1 is ignored, and the counter is not reloaded. The stall rule makes this unreachable in legal code.
  - `md_start_E` in the same cycle as `int_clr` is ignored: the E instruction is younger and is being flushed.
  - An exception or `eret` does not cancel a running count; the older mult/div completes.
- **Reset values:**
  - State RUN, `md_cnt`=0, `md_busy`=0.
  - Outputs while `reset`=1: `int_clr`=1 (matches the pipeline-register reset), `pc_sel`=00, `exl_set`=0, `en_F`=1, `en_D`=1, `clr_E`=0.

## Timing
- `int_clr`, `pc_sel`, `exl_set`, `en_*` and `clr_E` are combinational from current state and inputs.
- `md_cnt` and state are registered.
- **Exception:** `int_req_M` high in cycle T.
  - At the posedge ending T: the pipeline clears, PC loads 0x4180, CP0 sets EXL.
  - T+1 is EXC_FETCH; RUN resumes at T+2.
- **eret:** same shape as an exception, with PC loading EPC.
- **Mult:** `md_start_E` in cycle T gives `md_busy`=1 in T+1..T+5, `md_cnt` = 5,4,3,2,1, and `md_busy`=0 at T+6. Div gives `md_busy`=1 for T+1..T+10.
- **Load-use:** stall is asserted for exactly the cycles `load_use_D` is high; no extra latency.
- **Reset mid-operation:**
  - Reset during EXC_FETCH/ERET_FETCH returns to RUN on the next posedge.
  - Reset while busy zeroes `md_cnt` on the next posedge.
- **Simultaneous `int_req_M` and `eret_M`:** the exception wins; `pc_sel`=01 and `exl_set`=1.

## Test plan
- **Reset:** hold `reset` 2 cycles with `md_start_E`=1 → `md_cnt`=0, `md_busy`=0, `int_clr`=1, state RUN; the first cycle after reset shows `en_F`=1, `pc_sel`=00.
- **Div then mfhi:** pulse `md_start_E`=1 with `md_div_E`=1, then hold `md_use_D`=1 → stall (`en_F`=0, `clr_E`=1) for 11 cycles. That is the start cycle plus 10 busy cycles. `md_cnt` sequence is 10→1, then 0.
- **Exception during stall:** `load_use_D`=1 and `int_req_M`=1 together → `int_clr`=1, `pc_sel`=01, `en_F`=1, `exl_set`=1. The next cycle shows `clr_E`=1, and `int_req_M`=1 is ignored.
- **Exception with mult:** `int_req_M`=1 with `md_start_E`=1 in the same cycle → `md_cnt` stays 0. The same exception while `md_cnt`=3 → the count continues 2, 1, 0.
- **eret:** `eret_M`=1 → `pc_sel`=10, `int_clr`=1, `exl_set`=0, then one ERET_FETCH cycle. With `eret_M`=`int_req_M`=1 → `pc_sel`=01.
- **Back-to-back exceptions:** `int_req_M` high for 3 consecutive cycles → `int_clr` pulses in cycles 1 and 3 only.

Source files
------------

// File: rtl/pipe_seq_ctrl.sv
// pipe_seq_ctrl: pipeline enables/flushes, PC select, exception/eret sequencing and mult/div busy counter (in: int_req_M, eret_M, load_use_D, md_start_E, md_div_E, md_use_D; out: en_F, en_D, clr_E, int_clr, pc_sel, exl_set, md_busy, md_cnt)
module pipe_seq_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       int_req_M,
  input  logic       eret_M,
  input  logic       load_use_D,
  input  logic       md_start_E,
  input  logic       md_div_E,
  input  logic       md_use_D,
  output logic       en_F,
  output logic       en_D,
  output logic       clr_E,
  output logic       int_clr,
  output logic [1:0] pc_sel,
  output logic       exl_set,
  output logic       md_busy,
  output logic [3:0] md_cnt
);
  typedef enum logic [1:0] {RUN, EXC_FETCH, ERET_FETCH} state_t;
  state_t state, state_nx;
  logic stall, md_load;
  assign md_busy = |md_cnt;
  assign stall = load_use_D | (md_use_D & (md_busy | md_start_E));
  assign md_load = md_start_E & ~md_busy & (state == RUN) & ~int_clr;
  always_ff @(posedge clk)
    if (reset) state <= RUN;
    else state <= state_nx;
  always_ff @(posedge clk)
    if (reset) md_cnt <= '0;
    else if (md_load) md_cnt <= md_div_E ? 4'(DIV_CYC) : 4'(MULT_CYC);
    else if (md_busy) md_cnt <= md_cnt - 4'd1;
  always_comb begin
    state_nx = RUN;
    int_clr = 1'b0;
    pc_sel = 2'b00;
    exl_set = 1'b0;
    en_F = 1'b1;
    en_D = 1'b1;
    clr_E = 1'b0;
    if (reset) begin
      int_clr = 1'b1;
    end else if (state != RUN) begin
      clr_E = 1'b1;
    end else if (int_req_M) begin
      int_clr = 1'b1;
      pc_sel = 2'b01;
      exl_set = 1'b1;
      state_nx = EXC_FETCH;
    end else if (eret_M) begin
      int_clr = 1'b1;
      pc_sel = 2'b10;
      state_nx = ERET_FETCH;
    end else if (stall) begin
      en_F = 1'b0;
      en_D = 1'b0;
      clr_E = 1'b1;
    end
  end
endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// tb_pipe_seq_ctrl: directed plus randomized check of pipe_seq_ctrl against a behavioural model
module tb_pipe_seq_ctrl;
  localparam int MULT = 5;
  localparam int DIV = 10;
  logic clk = 1'b0;
  logic reset, int_req_M, eret_M, load_use_D, md_start_E, md_div_E, md_use_D;
  logic en_F, en_D, clr_E, int_clr, exl_set, md_busy;
  logic [1:0] pc_sel;
  logic [3:0] md_cnt;
  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;
  bit m_fetch = 1'b0;
  int m_cnt = 0;
  int w_cnt = -1, w_busy = -1, w_ic = -1, w_pc = -1, w_en = -1, w_ce = -1, w_exl = -1;

  pipe_seq_ctrl #(.MULT_CYC(MULT), .DIV_CYC(DIV)) dut (
    .clk(clk), .reset(reset), .int_req_M(int_req_M), .eret_M(eret_M),
    .load_use_D(load_use_D), .md_start_E(md_start_E), .md_div_E(md_div_E),
    .md_use_D(md_use_D), .en_F(en_F), .en_D(en_D), .clr_E(clr_E),
    .int_clr(int_clr), .pc_sel(pc_sel), .exl_set(exl_set),
    .md_busy(md_busy), .md_cnt(md_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", n, a, e, $time);
    end
  endtask

  // Model: a pending one-cycle fetch slot after any flush, and a plain integer countdown.
  always @(posedge clk) begin
    if (reset) begin
      m_fetch <= 1'b0;
      m_cnt <= 0;
    end else begin
      m_fetch <= !m_fetch && (int_req_M || eret_M);
      if (md_start_E && m_cnt == 0 && !m_fetch && !int_req_M && !eret_M)
        m_cnt <= md_div_E ? DIV : MULT;
      else if (m_cnt > 0)
        m_cnt <= m_cnt - 1;
    end
  end

  always @(negedge clk) if (chk_on) begin
    bit live, fi, fe, st;
    live = !reset && !m_fetch;
    fi = live && int_req_M;
    fe = live && !int_req_M && eret_M;
    st = live && !fi && !fe && (load_use_D || (md_use_D && (m_cnt > 0 || md_start_E)));
    chk("int_clr", int'(int_clr), int'(reset || fi || fe));
    chk("pc_sel", int'(pc_sel), fi ? 1 : fe ? 2 : 0);
    chk("exl_set", int'(exl_set), int'(fi));
    chk("en_F", int'(en_F), int'(!st));
    chk("en_D", int'(en_D), int'(!st));
    chk("clr_E", int'(clr_E), int'((!reset && m_fetch) || st));
    chk("md_busy", int'(md_busy), int'(m_cnt > 0));
    chk("md_cnt", int'(md_cnt), m_cnt);
    if (w_cnt >= 0) chk("lit_md_cnt", int'(md_cnt), w_cnt);
    if (w_busy >= 0) chk("lit_md_busy", int'(md_busy), w_busy);
    if (w_ic >= 0) chk("lit_int_clr", int'(int_clr), w_ic);
    if (w_pc >= 0) chk("lit_pc_sel", int'(pc_sel), w_pc);
    if (w_en >= 0) chk("lit_en_F", int'(en_F), w_en);
    if (w_ce >= 0) chk("lit_clr_E", int'(clr_E), w_ce);
    if (w_exl >= 0) chk("lit_exl_set", int'(exl_set), w_exl);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    {w_cnt, w_busy, w_ic, w_pc, w_en, w_ce, w_exl} = {7{-32'sd1}};
  endtask

  initial begin
    reset = 1'b1; int_req_M = 1'b0; eret_M = 1'b0; load_use_D = 1'b0;
    md_start_E = 1'b1; md_div_E = 1'b1; md_use_D = 1'b0;
    tick();
    chk_on = 1'b1;
    w_cnt = 0; w_busy = 0; w_ic = 1;
    tick();
    reset = 1'b0; md_start_E = 1'b0;
    w_en = 1; w_pc = 0; w_ic = 0; w_cnt = 0;
    tick();
    md_start_E = 1'b1; md_div_E = 1'b1; md_use_D = 1'b1;
    w_en = 0; w_ce = 1; w_cnt = 0;
    tick();
    md_start_E = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      w_cnt = 11 - k; w_en = 0; w_ce = 1; w_busy = 1;
      tick();
    end
    w_cnt = 0; w_en = 1; w_busy = 0;
    tick();
    md_use_D = 1'b0;
    load_use_D = 1'b1; int_req_M = 1'b1;
    w_ic = 1; w_pc = 1; w_en = 1; w_exl = 1;
    tick();
    w_ce = 1; w_ic = 0; w_pc = 0; w_exl = 0;
    tick();
    load_use_D = 1'b0; int_req_M = 1'b0;
    tick();
    int_req_M = 1'b1; md_start_E = 1'b1; md_div_E = 1'b0;
    tick();
    int_req_M = 1'b0; md_start_E = 1'b0;
    w_cnt = 0;
    tick();
    md_start_E = 1'b1;
    tick();
    md_start_E = 1'b0;
    w_cnt = 5;
    tick();
    tick();
    int_req_M = 1'b1;
    w_cnt = 3;
    tick();
    int_req_M = 1'b0;
    w_cnt = 2;
    tick();
    w_cnt = 1;
    tick();
    w_cnt = 0; w_busy = 0;
    tick();
    eret_M = 1'b1;
    w_pc = 2; w_ic = 1; w_exl = 0;
    tick();
    eret_M = 1'b0;
    w_ce = 1; w_pc = 0; w_ic = 0;
    tick();
    eret_M = 1'b1; int_req_M = 1'b1;
    w_pc = 1; w_exl = 1;
    tick();
    eret_M = 1'b0; int_req_M = 1'b0;
    tick();
    int_req_M = 1'b1;
    w_ic = 1;
    tick();
    w_ic = 0;
    tick();
    w_ic = 1;
    tick();
    int_req_M = 1'b0;
    tick();
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(63) == 0);
      int_req_M = ($urandom_range(15) == 0);
      eret_M = ($urandom_range(15) == 0);
      load_use_D = ($urandom_range(5) == 0);
      md_start_E = ($urandom_range(4) == 0);
      md_div_E = 1'($urandom);
      md_use_D = ($urandom_range(2) == 0);
      tick();
    end
    @(negedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
